// File: rtl/zrc_hist_seq.sv
// -----------------------------------------------------------------------------
// zrc_hist_seq
//   Frame-level sequencer for the ZRC histogram / DDE path. While the field is
//   active it gates histogram accumulation. During vertical blanking it walks
//   the histogram RAM for the map/CDF builder, flips the ping-pong map bank
//   and then zeroes the histogram for the next frame. After every reset it
//   clears the whole histogram before accepting a frame.
//
// Ports
//   i_clk         single clock, rising edge
//   i_rst         synchronous reset, active low
//   i_field_vld   frame valid from sensor timing
//   i_line_vld    line valid, qualifies pixels
//   i_freeze      1 = keep current map (skip scan and bank swap)
//   i_scan_rdy    map builder accepts the current scan address
//   o_hist_wr_en  accumulate enable to histogram RAM (1-cycle latency)
//   o_scan_vld    scan address valid
//   o_scan_addr   bin being scanned (0 outside the scan)
//   o_scan_last   marks the final bin of the scan
//   o_clr_en      write-zero enable to histogram RAM
//   o_clr_addr    bin being cleared (0 outside a clear)
//   o_map_bank    map table bank used by pixel mapping
//   o_map_done    1-cycle pulse, new map bank selected
//   o_overrun     1-cycle pulse, field started while the sequencer was busy
//   o_busy        sequencer is in INIT, SCAN, SWAP or CLEAR
//   o_frame_cnt   number of frames accumulated, wraps
// -----------------------------------------------------------------------------
module zrc_hist_seq #(
  parameter int HIST_RAM_AW = 14,
  parameter int FRM_CNT_W   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_field_vld,
  input  logic                   i_line_vld,
  input  logic                   i_freeze,
  input  logic                   i_scan_rdy,
  output logic                   o_hist_wr_en,
  output logic                   o_scan_vld,
  output logic [HIST_RAM_AW-1:0] o_scan_addr,
  output logic                   o_scan_last,
  output logic                   o_clr_en,
  output logic [HIST_RAM_AW-1:0] o_clr_addr,
  output logic                   o_map_bank,
  output logic                   o_map_done,
  output logic                   o_overrun,
  output logic                   o_busy,
  output logic [FRM_CNT_W-1:0]   o_frame_cnt
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCUM,
    ST_SCAN,
    ST_SWAP,
    ST_CLEAR
  } state_t;

  // Final bin is detected by comparing against all-ones, never by wrap.
  localparam logic [HIST_RAM_AW-1:0] ADDR_LAST = '1;
  localparam logic [HIST_RAM_AW-1:0] ADDR_ONE  = {{(HIST_RAM_AW-1){1'b0}}, 1'b1};
  localparam logic [FRM_CNT_W-1:0]   FRM_ONE   = {{(FRM_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state;
  logic                   field_q;
  logic                   field_rise;
  logic                   field_fall;
  logic [HIST_RAM_AW-1:0] scan_addr_inc;
  logic [HIST_RAM_AW-1:0] clr_addr_inc;

  assign field_rise    = i_field_vld & ~field_q;
  assign field_fall    = ~i_field_vld & field_q;
  assign scan_addr_inc = o_scan_addr + ADDR_ONE;
  assign clr_addr_inc  = o_clr_addr + ADDR_ONE;

  // NOTE: every state and output bit is a flop updated with non-blocking
  // assignments; a later assignment in the same pass overrides an earlier
  // default, which is how the one-cycle pulses fall back to 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      // Reset aborts any phase at once; the map bank returns to 0 so a swap
      // can never be left half done.
      state        <= ST_INIT;
      field_q      <= 1'b0;
      o_hist_wr_en <= 1'b0;
      o_scan_vld   <= 1'b0;
      o_scan_addr  <= '0;
      o_scan_last  <= 1'b0;
      o_clr_en     <= 1'b0;
      o_clr_addr   <= '0;
      o_map_bank   <= 1'b0;
      o_map_done   <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      field_q      <= i_field_vld;
      o_hist_wr_en <= 1'b0;
      o_map_done   <= 1'b0;
      o_overrun    <= 1'b0;

      // A field starting while blanking work is in progress is reported and
      // dropped; the sequence itself carries on untouched. Back in IDLE the
      // registered field copy is already high, so no rising edge is seen
      // until the following frame.
      if (field_rise && (state inside {ST_INIT, ST_SCAN, ST_SWAP, ST_CLEAR}))
        o_overrun <= 1'b1;

      case (state)
        ST_INIT: begin
          o_busy <= 1'b1;
          if (!o_clr_en) begin
            // First cycle out of reset: start the clear at bin 0.
            o_clr_en   <= 1'b1;
            o_clr_addr <= '0;
          end else if (o_clr_addr == ADDR_LAST) begin
            o_clr_en   <= 1'b0;
            o_clr_addr <= '0;
            o_busy     <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            o_clr_addr <= clr_addr_inc;
          end
        end

        ST_IDLE: begin
          if (field_rise) begin
            state        <= ST_ACCUM;
            // Pixel on the very first field cycle is accumulated too.
            o_hist_wr_en <= i_line_vld;
          end
        end

        ST_ACCUM: begin
          if (field_fall) begin
            o_frame_cnt <= o_frame_cnt + FRM_ONE;
            o_busy      <= 1'b1;
            // Freeze is only looked at here; changes later in the blanking
            // interval take effect on the next frame.
            if (i_freeze) begin
              state      <= ST_CLEAR;
              o_clr_en   <= 1'b1;
              o_clr_addr <= '0;
            end else begin
              state       <= ST_SCAN;
              o_scan_vld  <= 1'b1;
              o_scan_addr <= '0;
              o_scan_last <= 1'b0;
            end
          end else begin
            o_hist_wr_en <= i_field_vld & i_line_vld;
          end
        end

        ST_SCAN: begin
          // o_scan_vld is held high for the whole state, so i_scan_rdy alone
          // completes a handshake.
          if (i_scan_rdy) begin
            if (o_scan_addr == ADDR_LAST) begin
              state       <= ST_SWAP;
              o_scan_vld  <= 1'b0;
              o_scan_addr <= '0;
              o_scan_last <= 1'b0;
              o_map_bank  <= ~o_map_bank;
              o_map_done  <= 1'b1;
            end else begin
              o_scan_addr <= scan_addr_inc;
              o_scan_last <= (scan_addr_inc == ADDR_LAST);
            end
          end
        end

        ST_SWAP: begin
          state      <= ST_CLEAR;
          o_clr_en   <= 1'b1;
          o_clr_addr <= '0;
        end

        ST_CLEAR: begin
          if (o_clr_addr == ADDR_LAST) begin
            o_clr_en   <= 1'b0;
            o_clr_addr <= '0;
            o_busy     <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            o_clr_addr <= clr_addr_inc;
          end
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zrc_hist_seq.sv
// -----------------------------------------------------------------------------
// tb_zrc_hist_seq
//   Self-checking bench for zrc_hist_seq with a 16-bin histogram. A table of
//   per-cycle vectors covers reset, the power-up clear and one full frame;
//   hand-written sequences cover stalled scans, freeze, overrun and a reset
//   in the middle of a scan.
// -----------------------------------------------------------------------------
module tb_zrc_hist_seq;

  localparam int AW  = 4;
  localparam int FCW = 8;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_field_vld;
  logic           i_line_vld;
  logic           i_freeze;
  logic           i_scan_rdy;
  logic           o_hist_wr_en;
  logic           o_scan_vld;
  logic [AW-1:0]  o_scan_addr;
  logic           o_scan_last;
  logic           o_clr_en;
  logic [AW-1:0]  o_clr_addr;
  logic           o_map_bank;
  logic           o_map_done;
  logic           o_overrun;
  logic           o_busy;
  logic [FCW-1:0] o_frame_cnt;

  int n_vec      = 0;
  int n_miss     = 0;
  int excl_viol  = 0;
  bit mon_en     = 1'b0;

  always #5 i_clk = ~i_clk;

  zrc_hist_seq #(
    .HIST_RAM_AW (AW),
    .FRM_CNT_W   (FCW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_field_vld  (i_field_vld),
    .i_line_vld   (i_line_vld),
    .i_freeze     (i_freeze),
    .i_scan_rdy   (i_scan_rdy),
    .o_hist_wr_en (o_hist_wr_en),
    .o_scan_vld   (o_scan_vld),
    .o_scan_addr  (o_scan_addr),
    .o_scan_last  (o_scan_last),
    .o_clr_en     (o_clr_en),
    .o_clr_addr   (o_clr_addr),
    .o_map_bank   (o_map_bank),
    .o_map_done   (o_map_done),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy),
    .o_frame_cnt  (o_frame_cnt)
  );

  typedef struct packed {
    logic          wr;
    logic          svld;
    logic [AW-1:0] saddr;
    logic          slast;
    logic          clr;
    logic [AW-1:0] caddr;
    logic          bank;
    logic          done;
    logic          ovr;
    logic          busy;
    logic [FCW-1:0] fcnt;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  fld;
    logic  ln;
    logic  frz;
    logic  rdy;
    outs_t exp;
  } vec_t;

  typedef struct {
    int n_scan;
    int n_clr;
    int n_done;
    int n_last;
    int n_ovr;
    int n_wr;
    int n_bad;
  } drain_t;

  vec_t vecs[$];

  // Phase exclusivity and idle-address rules, checked on every falling edge.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (int'(o_hist_wr_en) + int'(o_scan_vld) + int'(o_clr_en) > 1) excl_viol++;
      if (!o_scan_vld && (o_scan_addr != '0 || o_scan_last)) excl_viol++;
      if (!o_clr_en && o_clr_addr != '0) excl_viol++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic outs_t cur_outs();
    outs_t o;
    o = {o_hist_wr_en, o_scan_vld, o_scan_addr, o_scan_last, o_clr_en, o_clr_addr,
         o_map_bank, o_map_done, o_overrun, o_busy, o_frame_cnt};
    return o;
  endfunction

  function automatic outs_t mk(input logic wr, input logic svld, input logic [AW-1:0] saddr,
                               input logic slast, input logic clr, input logic [AW-1:0] caddr,
                               input logic bank, input logic done, input logic ovr,
                               input logic busy, input logic [FCW-1:0] fcnt);
    outs_t o;
    o = {wr, svld, saddr, slast, clr, caddr, bank, done, ovr, busy, fcnt};
    return o;
  endfunction

  task automatic add(input logic rst, input logic fld, input logic ln, input logic frz,
                     input logic rdy, input outs_t e);
    vec_t v;
    v.rst = rst; v.fld = fld; v.ln = ln; v.frz = frz; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive inputs, let one rising edge pass, sample 1 time unit later.
  task automatic cycle(input logic rst, input logic fld, input logic ln, input logic frz,
                       input logic rdy);
    i_rst = rst; i_field_vld = fld; i_line_vld = ln; i_freeze = frz; i_scan_rdy = rdy;
    @(posedge i_clk);
    #1;
  endtask

  // One frame: rising edge cycle, lines of px pixels each with 2 blank cycles,
  // then the falling edge cycle carrying the freeze value.
  task automatic run_frame(input int lines, input int px, input logic frz, output int n_wr);
    n_wr = 0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    if (o_hist_wr_en) n_wr++;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < px; p++) begin
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        if (o_hist_wr_en) n_wr++;
      end
      for (int b = 0; b < 2; b++) begin
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        if (o_hist_wr_en) n_wr++;
      end
    end
    cycle(1'b1, 1'b0, 1'b0, frz, 1'b1);
    if (o_hist_wr_en) n_wr++;
  endtask

  // Run until o_busy drops, counting events and checking address sequences.
  // rdy_toggle: i_scan_rdy goes 0,1,0,1.. (else held 1).
  // rise_in_clr: field and line go high once a clear cycle has been seen.
  task automatic drain(input bit rdy_toggle, input bit rise_in_clr, output drain_t r);
    logic [AW-1:0] p_saddr;
    logic [AW-1:0] p_caddr;
    logic [AW-1:0] e_addr;
    logic          p_svld;
    logic          p_clr;
    logic          rdy;
    logic          fld;
    bit            tog;
    bit            seen_clr;
    int            guard;
    r = '{default: 0};
    tog = 1'b0;
    seen_clr = 1'b0;
    guard = 0;
    forever begin
      if (o_scan_vld)   r.n_scan++;
      if (o_clr_en)     begin r.n_clr++; seen_clr = 1'b1; end
      if (o_map_done)   r.n_done++;
      if (o_overrun)    r.n_ovr++;
      if (o_hist_wr_en) r.n_wr++;
      if (o_scan_last) begin
        if (o_scan_addr == 4'hF) r.n_last++;
        else r.n_bad++;
      end
      if (!o_busy) break;
      if (guard == 200) begin r.n_bad++; break; end
      guard++;
      p_svld = o_scan_vld; p_saddr = o_scan_addr;
      p_clr = o_clr_en; p_caddr = o_clr_addr;
      rdy = rdy_toggle ? tog : 1'b1;
      tog = ~tog;
      fld = rise_in_clr & seen_clr;
      cycle(1'b1, fld, fld, 1'b0, rdy);
      if (p_svld) begin
        if (rdy && p_saddr == 4'hF) begin
          if (o_scan_vld) r.n_bad++;
        end else begin
          e_addr = rdy ? p_saddr + 4'd1 : p_saddr;
          if (!o_scan_vld || o_scan_addr != e_addr) r.n_bad++;
        end
      end
      if (o_clr_en) begin
        e_addr = p_clr ? p_caddr + 4'd1 : 4'd0;
        if (o_clr_addr != e_addr) r.n_bad++;
      end else if (p_clr && p_caddr != 4'hF) begin
        r.n_bad++;
      end
    end
  endtask

  initial begin
    drain_t dr;
    int     n_wr;
    int     guard;
    logic   exp_bank;
    logic [FCW-1:0] exp_fcnt;

    // ---------------- vector table: reset, power-up clear, one frame -------
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 16; k++)
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 4'd0, 0, 1, 4'(k), 0, 0, 0, 1, 8'd0));
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    // 4 lines x 8 pixels, scan ready tied high
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++)
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, mk(1, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, 8'd0));
      for (int b = 0; b < 2; b++)
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    end
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 1, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 8'd1));
    for (int k = 1; k < 16; k++)
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(0, 1, 4'(k), (k == 15), 0, 4'd0, 0, 0, 0, 1, 8'd1));
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 4'd0, 0, 0, 4'd0, 1, 1, 0, 1, 8'd1));
    for (int k = 0; k < 16; k++)
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 4'd0, 0, 1, 4'(k), 1, 0, 0, 1, 8'd1));
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 4'd0, 0, 0, 4'd0, 1, 0, 0, 0, 8'd1));

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].fld, vecs[i].ln, vecs[i].frz, vecs[i].rdy);
      check($sformatf("vec%0d", i), {8'd0, cur_outs()}, {8'd0, vecs[i].exp});
      mon_en = 1'b1;
    end
    exp_bank = 1'b1;
    exp_fcnt = 8'd1;

    // ---------------- stalled scan: rdy 1,0,1,0 from the falling edge -------
    run_frame(2, 4, 1'b0, n_wr);
    exp_fcnt++;
    check("stall_wr_cnt", n_wr, 8);
    check("stall_fcnt", o_frame_cnt, exp_fcnt);
    drain(1'b1, 1'b0, dr);
    check("stall_scan_cycles", dr.n_scan, 32);
    check("stall_last_cycles", dr.n_last, 2);
    check("stall_done", dr.n_done, 1);
    check("stall_clr_cycles", dr.n_clr, 16);
    check("stall_seq_errs", dr.n_bad, 0);
    exp_bank = ~exp_bank;
    check("stall_bank", o_map_bank, exp_bank);

    // ---------------- freeze at the field falling edge ----------------------
    run_frame(1, 4, 1'b1, n_wr);
    exp_fcnt++;
    check("frz_wr_cnt", n_wr, 4);
    check("frz_fcnt", o_frame_cnt, exp_fcnt);
    check("frz_no_scan", {o_scan_vld, o_clr_en}, 2'b01);
    drain(1'b0, 1'b0, dr);
    check("frz_scan_cycles", dr.n_scan, 0);
    check("frz_done", dr.n_done, 0);
    check("frz_clr_cycles", dr.n_clr, 16);
    check("frz_seq_errs", dr.n_bad, 0);
    check("frz_bank", o_map_bank, exp_bank);

    // ---------------- overrun: next field rises during CLEAR ----------------
    run_frame(1, 4, 1'b0, n_wr);
    exp_fcnt++;
    check("ovr_pre_wr_cnt", n_wr, 4);
    drain(1'b0, 1'b1, dr);
    exp_bank = ~exp_bank;
    check("ovr_pulses", dr.n_ovr, 1);
    check("ovr_wr_in_drain", dr.n_wr, 0);
    check("ovr_scan_cycles", dr.n_scan, 16);
    check("ovr_clr_cycles", dr.n_clr, 16);
    check("ovr_seq_errs", dr.n_bad, 0);
    n_wr = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      if (o_hist_wr_en || o_overrun) n_wr++;
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    if (o_hist_wr_en || o_overrun) n_wr++;
    check("ovr_dropped_frame_activity", n_wr, 0);
    check("ovr_dropped_fcnt", o_frame_cnt, exp_fcnt);
    check("ovr_dropped_busy", o_busy, 1'b0);
    run_frame(1, 4, 1'b1, n_wr);
    exp_fcnt++;
    check("ovr_next_wr_cnt", n_wr, 4);
    check("ovr_next_fcnt", o_frame_cnt, exp_fcnt);
    drain(1'b0, 1'b0, dr);
    check("ovr_next_clr_cycles", dr.n_clr, 16);
    check("ovr_next_bank", o_map_bank, exp_bank);

    // ---------------- reset in the middle of a scan -------------------------
    run_frame(1, 4, 1'b0, n_wr);
    exp_fcnt++;
    check("rst_pre_fcnt", o_frame_cnt, exp_fcnt);
    guard = 0;
    while (o_scan_addr != 4'd7 && guard < 40) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    check("rst_reach_addr7", o_scan_addr, 4'd7);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_all_zero", {8'd0, cur_outs()}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_init_start", {o_clr_en, o_clr_addr, o_busy}, {1'b1, 4'd0, 1'b1});
    drain(1'b0, 1'b0, dr);
    check("rst_init_clr_cycles", dr.n_clr, 16);
    check("rst_init_scan_cycles", dr.n_scan, 0);
    check("rst_init_seq_errs", dr.n_bad, 0);
    check("rst_post_bank_fcnt", {o_map_bank, o_frame_cnt}, 9'd0);

    check("phase_exclusion_errs", excl_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
